// File: rtl/fir_window_coef_loader.sv
// rtl/fir_window_coef_loader.sv - walks a window generator over 0..n-1 and fills the FIR coefficient RAM
module fir_window_coef_loader #(
    parameter int MAX_LEN = 1024,
    parameter int ADDR_W  = 10,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [3:0]        win_type_in,
    input  logic [15:0]       n_in,
    input  logic [7:0]        lgn_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              gen_en,
    output logic [3:0]        gen_win_type,
    output logic [15:0]       gen_n,
    output logic [7:0]        gen_lgn,
    output logic [15:0]       gen_i,
    input  logic              gen_busy,
    input  logic [15:0]       gen_win,
    output logic              coef_we,
    output logic [ADDR_W-1:0] coef_addr,
    output logic [15:0]       coef_data
);

    localparam int          CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [15:0] MAX_N = 16'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAITLO,
        S_WRITE,
        S_DONE
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  tmo_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic              gen_en_q;
    logic [3:0]        win_type_q;
    logic [15:0]       n_q;
    logic [7:0]        lgn_q;
    logic [15:0]       gen_i_q;
    logic              coef_we_q;
    logic [15:0]       coef_data_q;

    logic cfg_ok;
    logic last_sample;
    logic tmo_hit;

    assign cfg_ok      = (n_in != 16'd0) && (n_in <= MAX_N) &&
                         (win_type_in >= 4'd1) && (win_type_in <= 4'd6);
    assign last_sample = (gen_i_q == n_q - 16'd1);
    assign tmo_hit     = (tmo_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            tmo_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            gen_en_q    <= 1'b0;
            win_type_q  <= '0;
            n_q         <= '0;
            lgn_q       <= '0;
            gen_i_q     <= '0;
            coef_we_q   <= 1'b0;
            coef_data_q <= '0;
        end else begin
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            coef_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // abort is deliberately not looked at here so start wins
                    if (start) begin
                        if (cfg_ok) begin
                            win_type_q <= win_type_in;
                            n_q        <= n_in;
                            lgn_q      <= lgn_in;
                            gen_i_q    <= '0;
                            busy_q     <= 1'b1;
                            gen_en_q   <= 1'b1;
                            tmo_q      <= '0;
                            state_q    <= S_REQ;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (abort || (!gen_busy && tmo_hit)) begin
                        gen_en_q <= 1'b0;
                        err_q    <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end else if (gen_busy) begin
                        gen_en_q <= 1'b0;
                        tmo_q    <= '0;
                        state_q  <= S_WAITLO;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_WAITLO: begin
                    if (abort || (gen_busy && tmo_hit)) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (!gen_busy) begin
                        coef_data_q <= gen_win;
                        coef_we_q   <= 1'b1;
                        state_q     <= S_WRITE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                S_WRITE: begin
                    // the strobe for this cycle is already on the RAM port
                    if (abort) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (last_sample) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        gen_i_q  <= gen_i_q + 16'd1;
                        gen_en_q <= 1'b1;
                        tmo_q    <= '0;
                        state_q  <= S_REQ;
                    end
                end
                S_DONE: begin
                    if (abort) begin
                        err_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q   <= 1'b0;
                    gen_en_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign gen_en       = gen_en_q;
    assign gen_win_type = win_type_q;
    assign gen_n        = n_q;
    assign gen_lgn      = lgn_q;
    assign gen_i        = gen_i_q;
    assign coef_we      = coef_we_q;
    assign coef_addr    = gen_i_q[ADDR_W-1:0];
    assign coef_data    = coef_data_q;

endmodule

// File: tb/tb_fir_window_coef_loader.sv
// tb/tb_fir_window_coef_loader.sv - randomized bench with generator responder and table reference model
module tb_fir_window_coef_loader;

    localparam int MAX_LEN = 1024;
    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 200;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [3:0]        win_type_in;
    logic [15:0]       n_in;
    logic [7:0]        lgn_in;
    logic              busy;
    logic              done;
    logic              err;
    logic              gen_en;
    logic [3:0]        gen_win_type;
    logic [15:0]       gen_n;
    logic [7:0]        gen_lgn;
    logic [15:0]       gen_i;
    logic              gen_busy;
    logic [15:0]       gen_win;
    logic              coef_we;
    logic [ADDR_W-1:0] coef_addr;
    logic [15:0]       coef_data;

    fir_window_coef_loader #(
        .MAX_LEN(MAX_LEN),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .win_type_in (win_type_in),
        .n_in        (n_in),
        .lgn_in      (lgn_in),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .gen_en      (gen_en),
        .gen_win_type(gen_win_type),
        .gen_n       (gen_n),
        .gen_lgn     (gen_lgn),
        .gen_i       (gen_i),
        .gen_busy    (gen_busy),
        .gen_win     (gen_win),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Window sample as the generator would compute it; Hann uses denominator n so n/2 is the peak.
    function automatic int win_val(input int t, input int n, input int i);
        real x;
        logic signed [15:0] v;
        if (t == 1) return 32767;
        if (t == 4) begin
            x = 32767.0 * (0.5 - 0.5 * $cos(2.0 * 3.141592653589793 * i / n));
            return int'(x);
        end
        v = 16'(t * 4099 + i * 37 + n * 11);
        return int'(v);
    endfunction

    // Behavioural generator: busy for a random latency after a trigger, result valid once busy falls.
    int lat_min = 5;
    int lat_max = 5;
    bit mute    = 1'b0;
    int m_cnt   = 0;

    initial begin
        gen_busy = 1'b0;
        gen_win  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                gen_busy = 1'b0;
                m_cnt    = 0;
            end else if (gen_busy) begin
                m_cnt--;
                if (m_cnt <= 0) begin
                    gen_busy = 1'b0;
                    gen_win  = 16'(win_val(int'(gen_win_type), int'(gen_n), int'(gen_i)));
                end
            end else if (gen_en && !mute) begin
                gen_busy = 1'b1;
                gen_win  = 16'($urandom);
                m_cnt    = $urandom_range(lat_max, lat_min);
            end
        end
    end

    int wq_addr[$];
    int wq_data[$];
    int wq_lgn[$];
    int done_cnt, err_cnt, overlap_cnt, en_cycles, busy_cnt;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (coef_we === 1'b1) begin
                wq_addr.push_back(int'(coef_addr));
                wq_data.push_back(int'($signed(coef_data)));
                wq_lgn.push_back(int'(gen_lgn));
            end
            if (done === 1'b1) done_cnt++;
            if (err === 1'b1) err_cnt++;
            if (gen_en === 1'b1 && gen_busy === 1'b1) overlap_cnt++;
            if (gen_en === 1'b1) en_cycles++;
            if (busy === 1'b1) busy_cnt++;
        end
    end

    task automatic clr();
        wq_addr.delete();
        wq_data.delete();
        wq_lgn.delete();
        done_cnt    = 0;
        err_cnt     = 0;
        overlap_cnt = 0;
        en_cycles   = 0;
        busy_cnt    = 0;
    endtask

    task automatic start_load(input int t, input int n, input int lgn, input bit with_abort);
        @(negedge clk);
        win_type_in = 4'(t);
        n_in        = 16'(n);
        lgn_in      = 8'(lgn);
        start       = 1'b1;
        abort       = with_abort;
        @(negedge clk);
        start       = 1'b0;
        abort       = 1'b0;
        win_type_in = 4'($urandom);
        n_in        = 16'($urandom);
        lgn_in      = 8'($urandom);
    endtask

    task automatic wait_end(input string tag, input int budget);
        int c = 0;
        while (done_cnt == 0 && err_cnt == 0 && c < budget) begin
            @(posedge clk);
            c++;
        end
        chk({tag, "_finished"}, 32'(c < budget), 32'd1);
        repeat (4) @(posedge clk);
        #2;
    endtask

    task automatic wait_index(input string tag, input int idx);
        int c = 0;
        while (!(gen_en === 1'b1 && int'(gen_i) == idx) && c < 5000) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk({tag, "_reached_index"}, 32'(c < 5000), 32'd1);
    endtask

    task automatic check_load(input string tag, input int t, input int n, input int lgn);
        int bad_addr = 0;
        int bad_data = 0;
        chk({tag, "_writes"}, 32'(wq_addr.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i >= wq_addr.size() || wq_addr[i] != (i % (1 << ADDR_W))) bad_addr++;
            if (i >= wq_data.size() || wq_data[i] != win_val(t, n, i)) bad_data++;
        end
        chk({tag, "_bad_addr"}, 32'(bad_addr), 32'd0);
        chk({tag, "_bad_data"}, 32'(bad_data), 32'd0);
        chk({tag, "_lgn"}, 32'((wq_lgn.size() > 0) ? wq_lgn[0] : -1), 32'(lgn));
        chk({tag, "_done"}, 32'(done_cnt), 32'd1);
        chk({tag, "_err"}, 32'(err_cnt), 32'd0);
        chk({tag, "_en_busy_overlap"}, 32'(overlap_cnt), 32'd0);
        chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, n, lgn, sz;
        rst_n       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        win_type_in = '0;
        n_in        = '0;
        lgn_in      = '0;
        clr();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_gen_en", 32'(gen_en), 0);
        chk("rst_coef_we", 32'(coef_we), 0);
        chk("rst_gen_i", 32'(gen_i), 0);
        chk("rst_gen_n", 32'(gen_n), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        clr();
        start_load(1, 64, 6, 1'b0);
        wait_end("rect64", 3000);
        check_load("rect64", 1, 64, 6);

        clr();
        start_load(4, 64, 6, 1'b0);
        wait_end("hann64", 3000);
        check_load("hann64", 4, 64, 6);
        chk("hann_addr0", 32'((wq_data.size() > 0) ? wq_data[0] : -1), 32'(win_val(4, 64, 0)));
        chk("hann_peak", 32'((wq_data.size() > 32) ? wq_data[32] : -1), 32'd32767);

        for (int k = 0; k < 3; k++) begin
            clr();
            case (k)
                0:       start_load(1, 0, 0, 1'b0);
                1:       start_load(1, MAX_LEN + 1, 10, 1'b0);
                default: start_load(7, 16, 4, 1'b0);
            endcase
            repeat (4) @(posedge clk);
            #2;
            chk($sformatf("bad_cfg%0d_err", k), 32'(err_cnt), 32'd1);
            chk($sformatf("bad_cfg%0d_writes", k), 32'(wq_addr.size()), 32'd0);
            chk($sformatf("bad_cfg%0d_busy", k), 32'(busy_cnt), 32'd0);
        end

        clr();
        mute = 1'b1;
        start_load(1, 8, 3, 1'b0);
        wait_end("timeout", TIMEOUT + 100);
        chk("timeout_err", 32'(err_cnt), 32'd1);
        chk("timeout_en_cycles", 32'(en_cycles >= TIMEOUT && en_cycles <= TIMEOUT + 1), 32'd1);
        chk("timeout_writes", 32'(wq_addr.size()), 32'd0);
        chk("timeout_gen_en", 32'(gen_en), 32'd0);
        chk("timeout_busy", 32'(busy), 32'd0);
        mute = 1'b0;

        lat_min = 2;
        lat_max = 4;
        clr();
        start_load(1, 64, 6, 1'b0);
        wait_index("abort", 10);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        repeat (12) @(posedge clk);
        #2;
        sz = wq_addr.size();
        chk("abort_write_count", 32'(sz == 10 || sz == 11), 32'd1);
        chk("abort_last_addr", 32'((sz > 0) ? wq_addr[sz-1] : -1), 32'(sz - 1));
        chk("abort_err", 32'(err_cnt), 32'd1);
        chk("abort_done", 32'(done_cnt), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);

        clr();
        start_load(2, 64, 6, 1'b0);
        wait_index("reset", 5);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_gen_en", 32'(gen_en), 0);
        chk("arst_gen_i", 32'(gen_i), 0);
        chk("arst_coef_we", 32'(coef_we), 0);
        chk("arst_coef_data", 32'(coef_data), 0);
        sz = wq_addr.size();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        chk("arst_no_err", 32'(err_cnt), 32'd0);
        chk("arst_no_more_writes", 32'(wq_addr.size()), 32'(sz));

        clr();
        start_load(5, 1, 0, 1'b1);
        wait_end("n1", 500);
        check_load("n1", 5, 1, 0);

        clr();
        start_load(3, 20, 5, 1'b0);
        repeat (15) @(negedge clk);
        win_type_in = 4'd2;
        n_in        = 16'd5;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end("restart", 2000);
        check_load("restart", 3, 20, 5);

        lat_min = 1;
        lat_max = 6;
        for (int r = 0; r < 6; r++) begin
            t   = $urandom_range(6, 1);
            n   = $urandom_range(40, 1);
            lgn = $urandom_range(255, 0);
            clr();
            start_load(t, n, lgn, 1'b0);
            wait_end($sformatf("rnd%0d", r), 3000);
            check_load($sformatf("rnd%0d", r), t, n, lgn);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/fir_window_coef_loader.md
Name: fir_window_coef_loader

Overview:
Sequencer that drives Window_function_generator through its en/busy request handshake. It walks index i from 0 to n-1 and writes each returned window sample into the FIR coefficient RAM. Firmware or a top-level controller issues one start pulse, and the block fills the whole coefficient table without further intervention. It also guards against an unresponsive generator with a per-sample timeout.

Parameters:
MAX_LEN, 1024, largest accepted window length; n_in above this is rejected
ADDR_W, 10, coefficient RAM address width; must satisfy 2^ADDR_W >= MAX_LEN
TIMEOUT, 4096, maximum cycles spent waiting for a gen_busy edge before aborting

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a table load
abort  in  1  synchronous cancel of a load in progress
win_type_in  in  4  window type: 1 rect, 2 Tukey, 3 tri, 4 Hann, 5 Hamming, 6 Blackman
n_in  in  16  window length
lgn_in  in  8  log2 length, passed through to the generator unchanged
busy  out  1  high from accept of start until return to IDLE
done  out  1  one-cycle pulse after the last coefficient is written
err  out  1  one-cycle pulse on rejected start, timeout, or abort
gen_en  out  1  generator trigger
gen_win_type  out  4  latched win_type_in
gen_n  out  16  latched n_in
gen_lgn  out  8  latched lgn_in
gen_i  out  16  current sample index
gen_busy  in  1  generator busy
gen_win  in  16  signed generator output, valid once gen_busy has fallen
coef_we  out  1  coefficient RAM write strobe
coef_addr  out  ADDR_W  write address, equal to gen_i[ADDR_W-1:0]
coef_data  out  16  signed write data

Behaviour:
- Reset, asynchronous: all outputs are 0 and the FSM is in IDLE. Assertion mid-load aborts immediately with no further writes; no err pulse is generated.
- States: IDLE, REQ, WAITLO, WRITE, DONE.
- IDLE:
  - start=1 with n_in in 1..MAX_LEN and win_type_in in 1..6: latch win_type, n and lgn, set gen_i=0, go to REQ, set busy=1 on the next edge.
  - start=1 with an invalid n_in or win_type_in: pulse err for one cycle, stay in IDLE, no writes.
- REQ: gen_en=1 and gen_i held stable. When gen_busy is sampled 1, drop gen_en on the next edge and go to WAITLO.
- WAITLO: gen_en=0. When gen_busy is sampled 0, register gen_win into coef_data and go to WRITE.
- WRITE: coef_we=1 for exactly one cycle with coef_addr=gen_i.
  - If gen_i==n-1: go to DONE.
  - Otherwise: gen_i increments and the FSM returns to REQ.
- DONE: pulse done for one cycle, clear busy, return to IDLE.
- Latency per sample: generator latency + 3 cycles (REQ edge, WAITLO exit, WRITE).
- Timeout: a counter is cleared on every entry to REQ and to WAITLO. If it reaches TIMEOUT while still in either state: gen_en=0, pulse err, go to IDLE, busy=0.
- abort=1 in any non-IDLE state:
  - gen_en drops on the next edge, err pulses, FSM goes to IDLE.
  - A WRITE already in its cycle completes.
  - abort takes priority over the timeout in the same cycle.
- start while busy=1 is ignored.
- start and abort together in IDLE: start is honoured.
- gen_i increments by exactly 1 per write and never exceeds n-1.
- n=1: a single write to address 0, then done.
- Latched configuration is held constant on gen_* for the whole load, even if the *_in inputs change.

Test Plan:
- Load with win_type=1, n=64, lgn=6 against a behavioural generator model (busy 5 cycles, win=32767) -> exactly 64 coef_we pulses at addresses 0..63, all data 32767, one done pulse, busy low afterwards.
- Load with win_type=4 (Hann), n=64 -> coefficient at address 0 equals the model's Hann(0), address 32 equals its peak; each gen_en high period ends the cycle after gen_busy rises.
- start with n_in=0, then n_in=MAX_LEN+1, then win_type_in=7 -> err pulses once for each, no coef_we, busy stays 0.
- Model holds gen_busy at 0 -> err pulses after TIMEOUT cycles in REQ, gen_en falls, zero writes.
- abort during sample 10 of a 64-length load, then rst_n pulsed low mid-load in a separate run:
  - abort run: writes stop at address 9 (or 10 if WRITE is in progress), err pulses.
  - reset run: outputs go to 0 asynchronously, no err.
- Load with n=1 -> one write at address 0 then done; a start issued during a load does not restart it (total write count unchanged).
